conv_pool_pingpong_buf: RTL and testbench
=========================================

Name: conv_pool_pingpong_buf

Overview:
- Parametrised ping-pong buffer between a convolution layer's output stream and a 2x2 pooling stage.
- Two banks, each holding two feature-map rows of ROW_W pixels. The writer fills one bank while the reader drains the other.
- The reader emits each bank as a pixel stream in 2x2-window order.
- Valid/ready handshakes on both sides give backpressure in both directions.

Parameters:
- DATA_W, 8, pixel width in bits.
- ROW_W, 8, pixels per row. Must be even and at least 2.
- AW, 5, bank address width. Must satisfy 2^AW >= 2*ROW_W.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- wr_valid  in  1  input pixel valid
- wr_ready  out  1  buffer can accept a pixel
- wr_data  in  DATA_W  input pixel, row-major order
- rd_valid  out  1  rd_data valid
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  DATA_W  output pixel, window order
- rd_last  out  1  high with the 4th pixel of each 2x2 window
- rd_bank_end  out  1  high with the final pixel of a bank
- bank_full  out  2  per-bank full flags (status)

Behaviour:
- Storage: 2 banks x 2*ROW_W words of DATA_W. Bank address: row0 = 0..ROW_W-1, row1 = ROW_W..2*ROW_W-1. Storage is not cleared at reset.
- Reset (rst=0 at a clk edge): wbank=0, waddr=0, rbank=0, win=0, elem=0, bank_full=2'b00, rd_valid=0, rd_data=0, rd_last=0, rd_bank_end=0.
- wr_ready = rst & !bank_full[wbank]. It is 0 while rst is low.
- Write: on wr_valid & wr_ready, store wr_data at [wbank][waddr].
  - If waddr == 2*ROW_W-1: set bank_full[wbank], toggle wbank, waddr=0.
  - Otherwise waddr+1.
- Read address sequence per bank, for win k = 0..ROW_W/2-1 and elem e = 0..3:
  - e0 = 2k
  - e1 = 2k+1
  - e2 = ROW_W+2k
  - e3 = ROW_W+2k+1
- Issue condition: bank_full[rbank] & (!rd_valid | rd_ready).
- On issue, next edge: rd_data <= mem[rbank][addr], rd_valid <= 1, rd_last <= (e==3), rd_bank_end <= (e==3 & k==ROW_W/2-1). Then advance e, wrapping to k+1.
- On issuing the final element of a bank: clear bank_full[rbank], toggle rbank, k=0, e=0. The bank is writable on the following cycle.
- If no issue and rd_ready=1: rd_valid <= 0.
- If rd_valid=1 and rd_ready=0: rd_data, rd_last and rd_bank_end hold stable.
- Latency: a bank becomes full at edge N; its first pixel is presented (rd_valid=1) at edge N+1. Sustained throughput is 1 pixel/cycle on each side.
- Simultaneous events:
  - Set and clear of bank_full in the same cycle always target different banks. Both take effect.
  - A write completing bank A while the reader drains bank B does not stall either side.
  - The reader never reads a bank being written, and the writer never writes a full bank.
- Both banks full: wr_ready=0 until the reader issues the last element of rbank.
- Both banks empty: rd_valid falls after the last pixel is accepted.
- Reset mid-operation: all pointers and flags return to reset values at the next edge. Partially written or partially read data is discarded. Output flags drop to 0.

Test Plan:
- Reset then write 0..15 (ROW_W=8) with rd_ready=1 -> output 0,1,8,9, 2,3,10,11, 4,5,12,13, 6,7,14,15. rd_last on every 4th pixel; rd_bank_end only on 15. First rd_valid 1 cycle after the 16th write.
- Continuous write of 48 pixels (1..48), rd_ready=1 -> no wr_ready deassertion. Three banks' worth output in window order. bank_full alternates 01/10.
- rd_ready=0, write 32 pixels -> bank_full=11 and wr_ready=0 after pixel 32. A 33rd write is held until rd_ready=1 and bank 0's 16th pixel is accepted.
- Random rd_ready toggling on a 16-pixel bank -> rd_data stable while rd_valid & !rd_ready. No pixel dropped or duplicated.
- Assert rst low after 10 writes and 3 reads -> next cycle wr_ready=0, rd_valid=0, bank_full=00. After release, a fresh 16-pixel bank reads back correctly from address 0.
- ROW_W=2, AW=2 -> bank of 4 pixels a,b,c,d is output a,b,c,d with rd_last and rd_bank_end both high on d.

Source files
------------

// File: rtl/conv_pool_pingpong_buf.sv
// Two-bank ping-pong buffer between a conv output stream and a 2x2 pooling stage.
// The writer fills one bank row-major while the reader drains the other in 2x2-window order.
module conv_pool_pingpong_buf #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 8,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              rd_bank_end,
  output logic [1:0]        bank_full
);

  localparam logic [AW-1:0] LAST_WADDR = AW'(2*ROW_W-1);
  localparam logic [AW-1:0] ROW1_BASE  = AW'(ROW_W);
  localparam logic [AW-2:0] LAST_WIN   = (AW-1)'(ROW_W/2-1);

  logic [DATA_W-1:0] r_mem [0:2**(AW+1)-1];

  logic              r_wbank;
  logic [AW-1:0]     r_waddr;
  logic              r_rbank;
  logic [AW-2:0]     r_win;
  logic [1:0]        r_elem;
  logic [1:0]        r_bank_full;

  logic [DATA_W-1:0] r_rd_data_p1;
  logic              r_vld_p1;
  logic              r_last_p1;
  logic              r_bank_end_p1;

  logic              w_wr_fire;
  logic              w_wr_bank_done;
  logic              w_issue;
  logic              w_elem_last;
  logic              w_win_last;
  logic              w_rd_bank_done;
  logic [AW-1:0]     w_raddr;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;

  assign wr_ready       = rst & ~r_bank_full[r_wbank];
  assign w_wr_fire      = wr_valid & wr_ready;
  assign w_wr_bank_done = w_wr_fire & (r_waddr == LAST_WADDR);

  // Output register may refill when empty or when its current pixel is being taken.
  assign w_issue        = r_bank_full[r_rbank] & (~r_vld_p1 | rd_ready);
  assign w_elem_last    = (r_elem == 2'd3);
  assign w_win_last     = (r_win == LAST_WIN);
  assign w_rd_bank_done = w_issue & w_elem_last & w_win_last;

  // Window element e maps to column 2k + e[0] of row e[1].
  assign w_raddr = {r_win, r_elem[0]} + (r_elem[1] ? ROW1_BASE : '0);

  assign w_set = w_wr_bank_done ? (2'b01 << r_wbank) : 2'b00;
  assign w_clr = w_rd_bank_done ? (2'b01 << r_rbank) : 2'b00;

  always_ff @(posedge clk) begin
    if (w_wr_fire) r_mem[{r_wbank, r_waddr}] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wbank <= 1'b0;
      r_waddr <= '0;
    end else if (w_wr_fire) begin
      if (r_waddr == LAST_WADDR) begin
        r_wbank <= ~r_wbank;
        r_waddr <= '0;
      end else begin
        r_waddr <= r_waddr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_bank_full <= 2'b00;
    else      r_bank_full <= (r_bank_full | w_set) & ~w_clr;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rbank <= 1'b0;
      r_win   <= '0;
      r_elem  <= 2'd0;
    end else if (w_issue) begin
      if (w_elem_last) begin
        r_elem <= 2'd0;
        if (w_win_last) begin
          r_win   <= '0;
          r_rbank <= ~r_rbank;
        end else begin
          r_win <= r_win + (AW-1)'(1);
        end
      end else begin
        r_elem <= r_elem + 2'd1;
      end
    end
  end

  // Stage p1: registered read port, held while the consumer stalls.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data_p1  <= '0;
      r_vld_p1      <= 1'b0;
      r_last_p1     <= 1'b0;
      r_bank_end_p1 <= 1'b0;
    end else if (w_issue) begin
      r_rd_data_p1  <= r_mem[{r_rbank, w_raddr}];
      r_vld_p1      <= 1'b1;
      r_last_p1     <= w_elem_last;
      r_bank_end_p1 <= w_elem_last & w_win_last;
    end else if (rd_ready) begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign rd_data     = r_rd_data_p1;
  assign rd_valid    = r_vld_p1;
  assign rd_last     = r_last_p1;
  assign rd_bank_end = r_bank_end_p1;
  assign bank_full   = r_bank_full;

endmodule

// File: tb/tb_conv_pool_pingpong_buf.sv
// Directed/random bench for conv_pool_pingpong_buf with a queue-based window-order reference model.
module tb_conv_pool_pingpong_buf;

  localparam int RW   = 8;
  localparam int BANK = 2 * RW;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid, wr_ready, rd_valid, rd_ready, rd_last, rd_bank_end;
  logic [7:0] wr_data, rd_data;
  logic [1:0] bank_full;

  logic       w2_valid, w2_ready, rd2_valid, rd2_ready, rd2_last, rd2_bend;
  logic [7:0] w2_data, rd2_data;
  logic [1:0] bf2;

  always #5 clk = ~clk;

  conv_pool_pingpong_buf #(.DATA_W(8), .ROW_W(RW), .AW(5)) u_dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rd_bank_end(rd_bank_end), .bank_full(bank_full)
  );

  conv_pool_pingpong_buf #(.DATA_W(8), .ROW_W(2), .AW(2)) u_dut2 (
    .clk(clk), .rst(rst), .wr_valid(w2_valid), .wr_ready(w2_ready), .wr_data(w2_data),
    .rd_valid(rd2_valid), .rd_ready(rd2_ready), .rd_data(rd2_data), .rd_last(rd2_last),
    .rd_bank_end(rd2_bend), .bank_full(bf2)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       bend;
  } exp_t;

  int         n_checks = 0;
  int         n_fails  = 0;
  logic [7:0] src_q[$];
  logic [7:0] bank_buf[$];
  exp_t       exp_q[$];
  int         rd_mode = 0;
  bit         wr_rand = 1'b0;
  int         rd_acc = 0;
  int         wr_at_rd = -1;
  int         stalls = 0;
  bit         saw11 = 1'b0;
  bit         hold_pend = 1'b0;
  logic [7:0] hold_d;
  logic       hold_l, hold_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Position in a row-major bank of the j-th pixel in 2x2-window order.
  function automatic int win_idx(input int rw, input int j);
    int k, e;
    k = j / 4;
    e = j % 4;
    return (e / 2) * rw + 2 * k + (e % 2);
  endfunction

  task automatic build_expected();
    for (int j = 0; j < BANK; j++) begin
      exp_t t;
      t.d    = bank_buf[win_idx(RW, j)];
      t.last = (j % 4 == 3);
      t.bend = (j == BANK - 1);
      exp_q.push_back(t);
    end
    bank_buf.delete();
  endtask

  task automatic tick();
    bit   wf, rf;
    exp_t e;
    wr_valid = (src_q.size() > 0) && (!wr_rand || $urandom_range(0, 1) == 1);
    wr_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
    rd_ready = (rd_mode == 1) ? 1'b1 : (rd_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
    @(negedge clk);
    if (rst) begin
      wf = wr_valid && wr_ready;
      rf = rd_valid && rd_ready;
      if (wr_valid && !wr_ready) stalls++;
      if (bank_full == 2'b11) saw11 = 1'b1;
      if (hold_pend) begin
        chk("hold_valid", 32'(rd_valid), 32'(1));
        chk("hold_data", 32'(rd_data), 32'(hold_d));
        chk("hold_last", 32'(rd_last), 32'(hold_l));
        chk("hold_bank_end", 32'(rd_bank_end), 32'(hold_b));
      end
      hold_pend = rd_valid && !rd_ready;
      hold_d = rd_data;
      hold_l = rd_last;
      hold_b = rd_bank_end;
      if (rf) begin
        rd_acc++;
        chk("rd_extra_pixel", 32'(exp_q.size() != 0), 32'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rd_data", 32'(rd_data), 32'(e.d));
          chk("rd_last", 32'(rd_last), 32'(e.last));
          chk("rd_bank_end", 32'(rd_bank_end), 32'(e.bend));
        end
      end
      if (wf) begin
        wr_at_rd = rd_acc;
        bank_buf.push_back(src_q.pop_front());
        if (bank_buf.size() == BANK) build_expected();
      end
    end else begin
      hold_pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, input string tag);
    int c = 0;
    while ((exp_q.size() > 0 || src_q.size() > 0) && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 32'(exp_q.size() + src_q.size()), 32'(0));
  endtask

  task automatic write_until_sent(input int budget, input string tag);
    int c = 0;
    while (src_q.size() > 0 && c < budget) begin
      tick();
      c++;
    end
    chk(tag, 32'(src_q.size()), 32'(0));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, 32'(wr_ready), 32'(0));
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'(0));
    chk({tag, "_rd_data"}, 32'(rd_data), 32'(0));
    chk({tag, "_rd_last"}, 32'(rd_last), 32'(0));
    chk({tag, "_rd_bank_end"}, 32'(rd_bank_end), 32'(0));
    chk({tag, "_bank_full"}, 32'(bank_full), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] px[4];
    int         c;

    rst = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_ready = 1'b0;
    w2_valid = 1'b0; w2_data = 8'h00; rd2_ready = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    chk("reset_bf2", 32'(bf2), 32'(0));
    rst = 1'b1;
    #1;
    chk("release_wr_ready", 32'(wr_ready), 32'(1));

    // Single bank 0..15, consumer always ready.
    rd_mode = 1;
    for (int i = 0; i < BANK; i++) src_q.push_back(8'(i));
    write_until_sent(40, "t1_writes");
    chk("t1_bank_full", 32'(bank_full), 32'(2'b01));
    chk("t1_not_yet_valid", 32'(rd_valid), 32'(0));
    tick();
    chk("t1_first_valid", 32'(rd_valid), 32'(1));
    chk("t1_first_data", 32'(rd_data), 32'(exp_q[0].d));
    drain(60, "t1_drain");
    chk("t1_valid_falls", 32'(rd_valid), 32'(0));

    // 48 back-to-back pixels must stream without writer stalls.
    stalls = 0; saw11 = 1'b0;
    for (int i = 1; i <= 48; i++) src_q.push_back(8'(i));
    drain(200, "t2_drain");
    chk("t2_no_stall", 32'(stalls), 32'(0));
    chk("t2_never_both_full", 32'(saw11), 32'(0));
    chk("t2_bank_full_end", 32'(bank_full), 32'(0));

    // Consumer stalled: both banks fill, 33rd pixel waits for bank drain.
    rd_mode = 0;
    for (int i = 0; i < 2 * BANK; i++) src_q.push_back(8'(100 + i));
    write_until_sent(80, "t3_writes");
    chk("t3_both_full", 32'(bank_full), 32'(2'b11));
    chk("t3_wr_ready_low", 32'(wr_ready), 32'(0));
    src_q.push_back(8'hEE);
    repeat (5) tick();
    chk("t3_write_held", 32'(src_q.size()), 32'(1));
    rd_mode = 1; rd_acc = 0; wr_at_rd = -1;
    write_until_sent(40, "t3_write_released");
    chk("t3_write_after_16th", 32'(wr_at_rd), 32'(BANK));
    drain(60, "t3_drain");
    rd_mode = 0; rst = 1'b0;
    tick();
    exp_q.delete(); bank_buf.delete();
    rst = 1'b1;

    // Random backpressure on both sides.
    wr_rand = 1'b1; rd_mode = 2; rd_acc = 0;
    for (int i = 0; i < BANK; i++) src_q.push_back(8'($urandom));
    drain(500, "t4_drain");
    chk("t4_count", 32'(rd_acc), 32'(BANK));
    wr_rand = 1'b0;

    // Reset mid-operation: full bank, 10 into next, 3 reads taken.
    rd_mode = 0;
    for (int i = 0; i < BANK + 10; i++) src_q.push_back(8'($urandom));
    write_until_sent(80, "t5_writes");
    rd_mode = 1; rd_acc = 0; c = 0;
    while (rd_acc < 3 && c < 20) begin
      tick();
      c++;
    end
    chk("t5_three_reads", 32'(rd_acc), 32'(3));
    rd_mode = 0; rst = 1'b0;
    tick();
    check_reset_outputs("t5_reset");
    exp_q.delete(); bank_buf.delete();
    rst = 1'b1;
    rd_mode = 1; rd_acc = 0;
    for (int i = 0; i < BANK; i++) src_q.push_back(8'($urandom));
    drain(80, "t5_fresh_drain");
    chk("t5_fresh_count", 32'(rd_acc), 32'(BANK));

    // Minimal geometry: one window per bank.
    for (int i = 0; i < 4; i++) px[i] = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      w2_valid = 1'b1;
      w2_data  = px[i];
      @(negedge clk);
      chk("t6_wr_ready", 32'(w2_ready), 32'(1));
      @(posedge clk);
      #1;
    end
    w2_valid = 1'b0;
    chk("t6_bank_full", 32'(bf2), 32'(2'b01));
    chk("t6_not_yet_valid", 32'(rd2_valid), 32'(0));
    @(posedge clk);
    #1;
    for (int j = 0; j < 4; j++) begin
      chk("t6_valid", 32'(rd2_valid), 32'(1));
      chk("t6_data", 32'(rd2_data), 32'(px[win_idx(2, j)]));
      chk("t6_last", 32'(rd2_last), 32'(j == 3));
      chk("t6_bank_end", 32'(rd2_bend), 32'(j == 3));
      @(posedge clk);
      #1;
    end
    chk("t6_valid_falls", 32'(rd2_valid), 32'(0));
    chk("t6_bank_empty", 32'(bf2), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
